fp_sp_to_u32_pipe: RTL and testbench



---
 rtl/fp_sp_to_u32_pipe_if.sv | 14 +
 rtl/fp_sp_to_u32_pipe.sv | 111 +++++++++++
 tb/tb_fp_sp_to_u32_pipe.sv | 257 +++++++++++++++++++++++++
 3 files changed

// File: rtl/fp_sp_to_u32_pipe_if.sv
// Operand/result bundle for the FP_sp -> u32 converter.
// The master drives ce/valid_in/X; the slave (converter) returns the result.
interface fp_sp_to_u32_pipe_if;
  logic        ce;
  logic        valid_in;
  logic [33:0] X;
  logic        valid_out;
  logic [31:0] R;
  logic        invalid;
  logic        inexact;

  modport master (output ce, valid_in, X, input  valid_out, R, invalid, inexact);
  modport slave  (input  ce, valid_in, X, output valid_out, R, invalid, inexact);
endinterface

// File: rtl/fp_sp_to_u32_pipe.sv
// FloPoCo single-precision to unsigned 32-bit integer converter.
// Conversion is fully combinational in front of stage 1; the remaining stages only delay the result.
module fp_sp_to_u32_pipe #(
  parameter int NUM_STAGES = 6,
  parameter int ROUND_MODE = 0
) (
  input logic clk,
  input logic rst,
  fp_sp_to_u32_pipe_if.slave bus
);

  logic [1:0]  w_exn;
  logic        w_sgn;
  logic [7:0]  w_exp;
  logic [22:0] w_frac;
  logic [23:0] w_m;
  logic [4:0]  w_rsh;
  logic [3:0]  w_lsh;
  logic [47:0] w_ext;
  logic [31:0] w_int, w_mag, w_r;
  logic        w_g, w_s, w_inc, w_big, w_inv, w_inx;

  assign w_exn  = bus.X[33:32];
  assign w_sgn  = bus.X[31];
  assign w_exp  = bus.X[30:23];
  assign w_frac = bus.X[22:0];
  assign w_m    = {1'b1, w_frac};
  assign w_big  = (w_exp >= 8'd150);
  assign w_rsh  = 5'(8'd150 - w_exp);
  assign w_lsh  = 4'(w_exp - 8'd150);
  assign w_ext  = {w_m, 24'b0} >> w_rsh;

  // Integer part plus guard/sticky from the discarded fraction
  always_comb begin
    w_int = '0;
    w_g   = 1'b0;
    w_s   = 1'b0;
    if (w_big) begin
      w_int = {8'b0, w_m} << w_lsh;
    end else if (w_exp >= 8'd127) begin
      w_int = {8'b0, w_ext[47:24]};
      w_g   = w_ext[23];
      w_s   = |w_ext[22:0];
    end else begin
      w_g   = (w_exp == 8'd126);
      w_s   = (w_exp != 8'd126) | (|w_frac);
    end
  end

  assign w_inc = (ROUND_MODE == 1) & w_g & (w_s | w_int[0]);
  assign w_mag = w_int + 32'(w_inc);

  // Negative inputs with k>=23 are always nonzero even if the shift wrapped
  always_comb begin
    w_r   = '0;
    w_inv = 1'b0;
    w_inx = 1'b0;
    case (w_exn)
      2'b00: ;
      2'b11: w_inv = 1'b1;
      2'b10: begin
        w_inv = 1'b1;
        w_r   = w_sgn ? 32'h0 : 32'hFFFF_FFFF;
      end
      default: begin
        if (!w_sgn && w_exp >= 8'd159) begin
          w_r   = 32'hFFFF_FFFF;
          w_inv = 1'b1;
        end else if (w_sgn) begin
          if (w_big || w_mag != 32'h0) w_inv = 1'b1;
          else                         w_inx = w_g | w_s;
        end else begin
          w_r   = w_mag;
          w_inx = w_g | w_s;
        end
      end
    endcase
  end

  logic [NUM_STAGES-1:0] r_vld;
  logic [NUM_STAGES-1:0] r_inv;
  logic [NUM_STAGES-1:0] r_inx;
  logic [31:0]           r_r [NUM_STAGES];

  // Bubbles carry zeroed data so the pipe contents stay deterministic
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld <= '0;
      r_inv <= '0;
      r_inx <= '0;
      for (int i = 0; i < NUM_STAGES; i++) r_r[i] <= '0;
    end else if (bus.ce) begin
      r_vld[0] <= bus.valid_in;
      r_inv[0] <= bus.valid_in & w_inv;
      r_inx[0] <= bus.valid_in & w_inx;
      r_r[0]   <= bus.valid_in ? w_r : 32'h0;
      for (int i = 1; i < NUM_STAGES; i++) begin
        r_vld[i] <= r_vld[i-1];
        r_inv[i] <= r_inv[i-1];
        r_inx[i] <= r_inx[i-1];
        r_r[i]   <= r_r[i-1];
      end
    end
  end

  assign bus.valid_out = r_vld[NUM_STAGES-1];
  assign bus.invalid   = r_inv[NUM_STAGES-1];
  assign bus.inexact   = r_inx[NUM_STAGES-1];
  assign bus.R         = r_r[NUM_STAGES-1];

endmodule

// File: tb/tb_fp_sp_to_u32_pipe.sv
// Scoreboard bench for fp_sp_to_u32_pipe: one instance per rounding mode, driven in lockstep.
// Random operands are scored against a real-arithmetic reference; directed ones against fixed values.
module tb_fp_sp_to_u32_pipe;
  localparam int N = 6;

  typedef struct {
    logic [33:0] x;
    logic [31:0] r0; logic iv0; logic ix0;
    logic [31:0] r1; logic iv1; logic ix1;
    int          sedge;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        ce  = 1'b0;
  logic        vin = 1'b0;
  logic [33:0] x   = '0;

  int   n_chk  = 0;
  int   n_pass = 0;
  int   ce_cnt = 0;
  bit   upd    = 1'b0;
  exp_t sb[$];

  fp_sp_to_u32_pipe_if if0 ();
  fp_sp_to_u32_pipe_if if1 ();
  assign if0.ce = ce;  assign if0.valid_in = vin;  assign if0.X = x;
  assign if1.ce = ce;  assign if1.valid_in = vin;  assign if1.X = x;

  fp_sp_to_u32_pipe #(.NUM_STAGES(N), .ROUND_MODE(0)) u_rz (.clk(clk), .rst(rst), .bus(if0));
  fp_sp_to_u32_pipe #(.NUM_STAGES(N), .ROUND_MODE(1)) u_rn (.clk(clk), .rst(rst), .bus(if1));

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Count ce=1 edges outside reset; latency is measured in these
  always @(posedge clk) begin
    upd = rst && ce;
    if (upd) ce_cnt++;
  end

  function automatic void model(input logic [33:0] xx, input bit rm,
                                output logic [31:0] r, output logic iv, output logic ix);
    real a, t, f, q;
    int  k;
    r = '0; iv = 1'b0; ix = 1'b0;
    case (xx[33:32])
      2'b00: ;
      2'b11: iv = 1'b1;
      2'b10: begin iv = 1'b1; r = xx[31] ? 32'h0 : 32'hFFFF_FFFF; end
      default: begin
        k = int'(xx[30:23]) - 127;
        if (!xx[31] && k >= 32) begin
          r = 32'hFFFF_FFFF; iv = 1'b1;
        end else begin
          a = 1.0 + real'(xx[22:0]) / 8388608.0;
          if (k > 0) repeat (k) a = a * 2.0;
          else       repeat (-k) a = a / 2.0;
          t = $floor(a); f = a - t; q = t;
          if (rm && (f > 0.5 || (f == 0.5 && $floor(t / 2.0) * 2.0 != t))) q = t + 1.0;
          if (xx[31]) begin
            if (q != 0.0) iv = 1'b1;
            else          ix = (f != 0.0);
          end else begin
            r  = 32'(longint'(q));
            ix = (f != 0.0);
          end
        end
      end
    endcase
  endfunction

  // Scoreboard pop: only when the pipe actually advanced on the last edge
  always @(negedge clk) begin
    if (upd && (if0.valid_out || if1.valid_out)) begin
      exp_t e;
      n_chk++;
      if (sb.size() == 0) begin
        $display("FAIL sb_unexpected: valid_out rz=%0b rn=%0b with empty scoreboard", if0.valid_out, if1.valid_out);
      end else begin
        n_pass++;
        e = sb.pop_front();
        n_chk++;
        if (if0.valid_out !== 1'b1 || if0.R !== e.r0 || if0.invalid !== e.iv0 || if0.inexact !== e.ix0)
          $display("FAIL result_rz X=%h: got v=%0b R=%h inv=%0b inx=%0b, want v=1 R=%h inv=%0b inx=%0b",
                   e.x, if0.valid_out, if0.R, if0.invalid, if0.inexact, e.r0, e.iv0, e.ix0);
        else n_pass++;
        n_chk++;
        if (if1.valid_out !== 1'b1 || if1.R !== e.r1 || if1.invalid !== e.iv1 || if1.inexact !== e.ix1)
          $display("FAIL result_rn X=%h: got v=%0b R=%h inv=%0b inx=%0b, want v=1 R=%h inv=%0b inx=%0b",
                   e.x, if1.valid_out, if1.R, if1.invalid, if1.inexact, e.r1, e.iv1, e.ix1);
        else n_pass++;
        n_chk++;
        if (ce_cnt !== e.sedge + N - 1)
          $display("FAIL latency X=%h: result at ce edge %0d, want %0d", e.x, ce_cnt, e.sedge + N - 1);
        else n_pass++;
      end
    end
  end

  task automatic step(input logic c, input logic v, input logic [33:0] xx);
    @(negedge clk); #1;
    ce = c; vin = v; x = xx;
  endtask

  task automatic push_exp(input exp_t e);
    e.sedge = ce_cnt + 1;
    sb.push_back(e);
  endtask

  task automatic push_model(input logic [33:0] xx);
    exp_t e;
    e.x = xx;
    model(xx, 1'b0, e.r0, e.iv0, e.ix0);
    model(xx, 1'b1, e.r1, e.iv1, e.ix1);
    push_exp(e);
  endtask

  task automatic drain(input string nm);
    int t = 0;
    while (sb.size() > 0 && t < 200) begin
      step(1'b1, 1'b0, '0);
      t++;
    end
    n_chk++;
    if (sb.size() != 0) $display("FAIL drain_%s: %0d results outstanding, want 0", nm, sb.size());
    else n_pass++;
  endtask

  function automatic logic [33:0] rand_x();
    logic [1:0]  exn;
    logic [22:0] fr;
    int          r;
    r   = $urandom_range(0, 15);
    exn = (r == 0) ? 2'b00 : (r == 1) ? 2'b11 : (r == 2) ? 2'b10 : 2'b01;
    fr  = 23'($urandom);
    if ($urandom_range(0, 3) == 0) fr = fr & 23'h7F_0000;
    return {exn, 1'($urandom), 8'($urandom_range(100, 165)), fr};
  endfunction

  task automatic test_reset();
    exp_t one;
    one = '{x: 34'h1_3F80_0000, r0: 32'd1, iv0: 1'b0, ix0: 1'b0,
            r1: 32'd1, iv1: 1'b0, ix1: 1'b0, sedge: 0};
    rst = 1'b0; ce = 1'b1; vin = 1'b1;
    repeat (5) begin
      @(negedge clk);
      n_chk++;
      if ({if0.valid_out, if0.R, if0.invalid, if0.inexact, if1.valid_out, if1.R, if1.invalid, if1.inexact} !== '0)
        $display("FAIL reset_hold: rz v=%0b R=%h rn v=%0b R=%h, want all zero",
                 if0.valid_out, if0.R, if1.valid_out, if1.R);
      else n_pass++;
      #1 x = {2'($urandom), $urandom};
    end
    @(negedge clk); #1;
    rst = 1'b1; x = one.x;
    push_exp(one);
    for (int i = 1; i <= N; i++) begin
      @(negedge clk);
      n_chk++;
      if (if0.valid_out !== (i == N) || if1.valid_out !== (i == N))
        $display("FAIL reset_latency edge %0d: valid_out rz=%0b rn=%0b, want %0b", i, if0.valid_out, if1.valid_out, i == N);
      else n_pass++;
      #1;
      if (i < N) push_exp(one);
      else       vin = 1'b0;
    end
    drain("reset");
  endtask

  task automatic test_directed();
    exp_t tbl[$];
    tbl = '{
      '{34'h1_3F80_0000, 32'd1,          0, 0, 32'd1,          0, 0, 0},
      '{34'h1_4F7F_FFFF, 32'hFFFF_FF00,  0, 0, 32'hFFFF_FF00,  0, 0, 0},
      '{34'h1_4060_0000, 32'd3,          0, 1, 32'd4,          0, 1, 0},
      '{34'h1_4020_0000, 32'd2,          0, 1, 32'd2,          0, 1, 0},
      '{34'h1_3FC0_0000, 32'd1,          0, 1, 32'd2,          0, 1, 0},
      '{34'h1_3F00_0000, 32'd0,          0, 1, 32'd0,          0, 1, 0},
      '{34'h1_4F80_0000, 32'hFFFF_FFFF,  1, 0, 32'hFFFF_FFFF,  1, 0, 0},
      '{34'h2_0000_0000, 32'hFFFF_FFFF,  1, 0, 32'hFFFF_FFFF,  1, 0, 0},
      '{34'h2_8000_0000, 32'd0,          1, 0, 32'd0,          1, 0, 0},
      '{34'h3_7FC0_0000, 32'd0,          1, 0, 32'd0,          1, 0, 0},
      '{34'h1_BF80_0000, 32'd0,          1, 0, 32'd0,          1, 0, 0},
      '{34'h1_BE99_999A, 32'd0,          0, 1, 32'd0,          0, 1, 0},
      '{34'h1_BF00_0000, 32'd0,          0, 1, 32'd0,          0, 1, 0},
      '{34'h1_BF33_3333, 32'd0,          0, 1, 32'd0,          1, 0, 0},
      '{34'h0_FFFF_FFFF, 32'd0,          0, 0, 32'd0,          0, 0, 0},
      '{34'h1_0000_0000, 32'd0,          0, 1, 32'd0,          0, 1, 0}
    };
    foreach (tbl[i]) begin
      step(1'b1, 1'b1, tbl[i].x);
      push_exp(tbl[i]);
    end
    drain("directed");
  endtask

  task automatic test_back_to_back();
    logic [33:0] xx;
    logic        c, v;
    for (int i = 0; i < 120; i++) begin
      c  = ($urandom_range(0, 9) < 7);
      v  = ($urandom_range(0, 3) != 0);
      xx = rand_x();
      step(c, v, xx);
      if (c && v) push_model(xx);
    end
    drain("stall");
  endtask

  task automatic test_midstream_reset();
    for (int i = 0; i < N; i++) begin
      logic [33:0] xx;
      xx = rand_x();
      step(1'b1, 1'b1, xx);
      push_model(xx);
    end
    @(negedge clk); #1;
    rst = 1'b0; vin = 1'b0;
    sb.delete();
    @(negedge clk);
    n_chk++;
    if (if0.valid_out !== 1'b0 || if1.valid_out !== 1'b0 || if0.R !== 32'h0 || if1.R !== 32'h0)
      $display("FAIL midrst_clear: rz v=%0b R=%h rn v=%0b R=%h, want 0", if0.valid_out, if0.R, if1.valid_out, if1.R);
    else n_pass++;
    #1 rst = 1'b1;
    for (int i = 0; i < 2 * N; i++) begin
      step(1'b1, 1'b0, rand_x());
      n_chk++;
      if (if0.valid_out !== 1'b0 || if1.valid_out !== 1'b0)
        $display("FAIL midrst_bubble cycle %0d: valid_out rz=%0b rn=%0b, want 0", i, if0.valid_out, if1.valid_out);
      else n_pass++;
    end
    for (int i = 0; i < 4; i++) begin
      logic [33:0] xx;
      xx = rand_x();
      step(1'b1, 1'b1, xx);
      push_model(xx);
    end
    drain("midrst");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_back_to_back();
    test_midstream_reset();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
